// File: rtl/lui_op_extract.sv
// lui_op_extract: filters an RV32 instruction stream down to LUI words and
// queues each one's {rd, U-immediate} pair for the disassembly display stage.
// Non-LUI words are consumed and only counted. All state is synchronous to
// clk with an active-high synchronous reset.
module lui_op_extract #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_op,
  output logic [19:0]      out_imm,
  output logic [CNT_W-1:0] lui_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [6:0] LuiOpcode = 7'b0110111;

  logic [24:0]      mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [CNT_W-1:0] luiCnt_q, luiCnt_d;
  logic [CNT_W-1:0] dropCnt_q, dropCnt_d;

  logic full;
  logic empty;
  logic accept;
  logic isLui;
  logic push;
  logic pop;

  // Handshake decode: readiness comes only from registered occupancy plus
  // flush/rst, so a same-cycle pop never re-opens the input.
  always_comb begin
    full      = (occ_q == OW'(DEPTH));
    empty     = (occ_q == '0);
    in_ready  = !full && !flush && !rst;
    accept    = in_valid && in_ready;
    isLui     = (in_insn[6:0] == LuiOpcode);
    push      = accept && isLui;
    out_valid = !empty;
    pop       = out_valid && out_ready && !flush && !rst;
  end

  // Head entry presentation; fields read as zero whenever the FIFO is empty.
  always_comb begin
    out_op     = '0;
    out_imm    = '0;
    lui_count  = luiCnt_q;
    drop_count = dropCnt_q;
    if (!empty) begin
      out_op  = mem_q[rdPtr_q][24:20];
      out_imm = mem_q[rdPtr_q][19:0];
    end
  end

  // Next-state for pointers, occupancy and the saturating statistics counters.
  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    occ_d     = occ_q;
    luiCnt_d  = luiCnt_q;
    dropCnt_d = dropCnt_q;

    if (push) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase

    if (accept) begin
      if (isLui) begin
        if (luiCnt_q != '1) begin
          luiCnt_d = luiCnt_q + CNT_W'(1);
        end
      end else begin
        if (dropCnt_q != '1) begin
          dropCnt_d = dropCnt_q + CNT_W'(1);
        end
      end
    end

    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      occ_d   = '0;
    end
  end

  // Control state register; reset clears the FIFO and both counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      occ_q     <= '0;
      luiCnt_q  <= '0;
      dropCnt_q <= '0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      occ_q     <= occ_d;
      luiCnt_q  <= luiCnt_d;
      dropCnt_q <= dropCnt_d;
    end
  end

  // Entry storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= {in_insn[11:7], in_insn[31:12]};
    end
  end

endmodule

// File: tb/tb_lui_op_extract.sv
// Testbench for lui_op_extract: directed scenarios plus a randomized phase,
// all checked by a scoreboard that tracks the queued LUI entries.
module tb_lui_op_extract;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_op;
  logic [19:0] out_imm;
  logic [CNT_W-1:0] lui_count;
  logic [CNT_W-1:0] drop_count;

  // Second instance with narrow counters, used for the saturation scenario.
  logic        in_valid2;
  logic        in_ready2;
  logic [31:0] in_insn2;
  logic        out_valid2;
  logic        out_ready2;
  logic [4:0]  out_op2;
  logic [19:0] out_imm2;
  logic [3:0]  lui_count2;
  logic [3:0]  drop_count2;
  logic        flush2;

  int checks   = 0;
  int failures = 0;

  logic [24:0] scoreboard[$];
  int expLui  = 0;
  int expDrop = 0;
  localparam int CntMax = (1 << CNT_W) - 1;

  always #5 clk = ~clk;

  lui_op_extract #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_imm(out_imm),
    .lui_count(lui_count), .drop_count(drop_count)
  );

  lui_op_extract #(.DEPTH(4), .CNT_W(4)) dutSat (
    .clk(clk), .rst(rst), .flush(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_insn(in_insn2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_op(out_op2), .out_imm(out_imm2),
    .lui_count(lui_count2), .drop_count(drop_count2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mkLui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] mkOther();
    logic [31:0] w;
    w = $urandom;
    if (w[6:0] == 7'b0110111) w[6:0] = 7'b0010011;
    return w;
  endfunction

  // Drive one cycle worth of inputs; they are held across exactly one edge.
  task automatic applyStimulus(input logic v, input logic [31:0] insn, input logic ordy,
                               input logic fl, input logic rs);
    in_valid  = v;
    in_insn   = insn;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle(input logic ordy);
    in_valid  = 1'b0;
    in_insn   = '0;
    out_ready = ordy;
    flush     = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    setIdle(1'b0);
  endtask

  // Hold a word on the input until it is accepted, bounded by a cycle budget.
  task automatic sendWord(input logic [31:0] insn);
    logic got;
    got = 1'b0;
    in_valid = 1'b1;
    in_insn  = insn;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) break;
    end
    in_valid = 1'b0;
    if (!got) checkOutput("send_timeout", 32'd0, 32'd1);
  endtask

  // Monitor and reference model: compares DUT-visible state against the
  // scoreboard mid-cycle, then predicts the effect of the coming edge.
  always @(negedge clk) begin
    logic expReady;
    logic [31:0] w;
    expReady = (scoreboard.size() < DEPTH) && !flush && !rst;
    checkOutput("in_ready", 32'(in_ready), 32'(expReady));
    checkOutput("out_valid", 32'(out_valid), 32'(scoreboard.size() > 0));
    checkOutput("lui_count", 32'(lui_count), expLui);
    checkOutput("drop_count", 32'(drop_count), expDrop);
    if (scoreboard.size() > 0) begin
      checkOutput("out_op", 32'(out_op), 32'(scoreboard[0][24:20]));
      checkOutput("out_imm", 32'(out_imm), 32'(scoreboard[0][19:0]));
    end else begin
      checkOutput("empty_op", 32'(out_op), 32'd0);
      checkOutput("empty_imm", 32'(out_imm), 32'd0);
    end

    if (rst) begin
      scoreboard.delete();
      expLui  = 0;
      expDrop = 0;
    end else if (flush) begin
      scoreboard.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (scoreboard.size() == 0) checkOutput("pop_underflow", 32'd1, 32'd0);
        else void'(scoreboard.pop_front());
      end
      if (in_valid && expReady) begin
        w = in_insn;
        if (w[6:0] == 7'b0110111) begin
          scoreboard.push_back({w[11:7], w[31:12]});
          if (expLui < CntMax) expLui++;
        end else begin
          if (expDrop < CntMax) expDrop++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    in_valid2  = 1'b0;
    in_insn2   = '0;
    out_ready2 = 1'b1;
    flush2     = 1'b0;
    setIdle(1'b0);
    doReset();

    // Single LUI, then pop it.
    applyStimulus(1'b1, 32'h123450B7, 1'b0, 1'b0, 1'b0);
    setIdle(1'b0);
    @(negedge clk);
    checkOutput("single_valid", 32'(out_valid), 32'd1);
    checkOutput("single_op", 32'(out_op), 32'd1);
    checkOutput("single_imm", 32'(out_imm), 32'h12345);
    checkOutput("single_cnt", 32'(lui_count), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    setIdle(1'b0);
    @(negedge clk);
    checkOutput("single_popped_valid", 32'(out_valid), 32'd0);
    checkOutput("single_popped_op", 32'(out_op), 32'd0);

    // Filtering: ADDI nop is dropped, LUI x0 is kept.
    doReset();
    applyStimulus(1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hFFFFF037, 1'b0, 1'b0, 1'b0);
    setIdle(1'b0);
    @(negedge clk);
    checkOutput("filter_drop", 32'(drop_count), 32'd1);
    checkOutput("filter_lui", 32'(lui_count), 32'd1);
    checkOutput("filter_op", 32'(out_op), 32'd0);
    checkOutput("filter_imm", 32'(out_imm), 32'hFFFFF);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Full and back-pressure: six LUIs into a four-entry FIFO.
    doReset();
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, mkLui(5'(i), 20'(i * 16'h111)), 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_insn  = mkLui(5'd5, 20'h55555);
    @(negedge clk);
    checkOutput("full_stall", 32'(in_ready), 32'd0);
    checkOutput("full_cnt", 32'(lui_count), 32'd4);
    out_ready = 1'b1;
    sendWord(mkLui(5'd5, 20'h55555));
    sendWord(mkLui(5'd6, 20'h66666));
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    setIdle(1'b0);
    @(negedge clk);
    checkOutput("full_total", 32'(lui_count), 32'd6);
    checkOutput("full_drained", 32'(out_valid), 32'd0);

    // Streaming: back-to-back accepts with the downstream always ready.
    doReset();
    for (int i = 0; i < 20; i++) begin
      in_valid  = 1'b1;
      in_insn   = mkLui(5'(i % 32), 20'($urandom));
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("stream_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    setIdle(1'b1);
    @(negedge clk);
    checkOutput("stream_cnt", 32'(lui_count), 32'd20);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush mid-operation.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, mkLui(5'(i + 7), 20'($urandom)), 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_insn  = mkLui(5'd9, 20'h00009);
    flush    = 1'b1;
    @(negedge clk);
    checkOutput("flush_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    setIdle(1'b0);
    @(negedge clk);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_cnt", 32'(lui_count), 32'd3);

    // Reset mid-operation.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, mkLui(5'(i + 20), 20'($urandom)), 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_insn  = mkLui(5'd9, 20'h00009);
    rst      = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    setIdle(1'b0);
    @(negedge clk);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_cnt", 32'(lui_count), 32'd0);
    checkOutput("rst_ready_high", 32'(in_ready), 32'd1);

    // Saturation on the narrow-counter instance.
    for (int i = 0; i < 20; i++) begin
      in_valid2 = 1'b1;
      in_insn2  = 32'h00000013;
      @(posedge clk);
      #1;
    end
    in_valid2 = 1'b0;
    @(negedge clk);
    checkOutput("sat_drop", 32'(drop_count2), 32'd15);
    checkOutput("sat_lui", 32'(lui_count2), 32'd0);

    // Randomized traffic with occasional flush and reset.
    doReset();
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom % 4) != 0,
                    ($urandom % 2) ? mkLui(5'($urandom), 20'($urandom)) : mkOther(),
                    ($urandom % 3) != 0,
                    ($urandom % 40) == 0,
                    ($urandom % 150) == 0);
    end
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    setIdle(1'b0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lui_op_extract.md
# lui_op_extract

Upstream feeder for the RV32 disassembly display stage. Accepts a stream of 32-bit instruction words over a valid/ready handshake, keeps only LUI instructions, and queues each one's 5-bit destination-register index (the `op` index into the package `REGS` name table) plus its 20-bit immediate in a small FIFO. The downstream stage pops entries and formats them as `lui <reg>` lines. Non-LUI words are consumed and counted but not forwarded.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous FIFO clear; counters are unaffected.
- `in_valid`  in  1  instruction word present.
- `in_ready`  out  1  block accepts the word this cycle.
- `in_insn`  in  32  RV32 instruction word.
- `out_valid`  out  1  FIFO head entry valid.
- `out_ready`  in  1  downstream pops the head this cycle.
- `out_op`  out  5  rd field (`insn[11:7]`) of the head entry.
- `out_imm`  out  20  U-immediate (`insn[31:12]`) of the head entry.
- `lui_count`  out  CNT_W  LUI words accepted (saturating).
- `drop_count`  out  CNT_W  non-LUI words accepted (saturating).

## Operation
- Accept: when `in_valid && in_ready`.
- `in_ready = !full && !flush && !rst`.
- LUI detect: `in_insn[6:0] == 7'b0110111`. No other field is checked.
- Accepted LUI: push `{insn[11:7], insn[31:12]}` and increment `lui_count`. `rd == 0` is pushed like any other rd.
- Accepted non-LUI: no push; increment `drop_count`.
- Pop: when `out_valid && out_ready`; head pointer advances.
- FIFO:
  - Read and write pointers are `log2(DEPTH)` bits and wrap modulo DEPTH.
  - Occupancy counter is `log2(DEPTH)+1` bits.
  - `full` when occupancy == DEPTH; `empty` when occupancy == 0.
- Simultaneous push and pop (not full, not empty): both pointers advance; occupancy unchanged.
- Push while empty: no bypass. The entry is visible the next cycle.
- Push while full: impossible, because `in_ready` is 0. A pop in the same cycle does not re-open `in_ready` that cycle.
- `out_op` and `out_imm` show the head entry when `out_valid`, and are forced to 0 when empty.
- Counters:
  - Saturate at all-ones; no wrap.
  - Only `rst` clears them.
- `flush`:
  - Clears both pointers and occupancy next edge.
  - A pop asserted in the flush cycle is a no-op.
  - No word is accepted in the flush cycle.
- Reset, taking effect at the next edge:
  - Pointers, occupancy and both counters go to 0.
  - Outputs become `out_valid=0`, `out_op=0`, `out_imm=0`, `lui_count=0`, `drop_count=0`.
  - `in_ready=0` while `rst` is high and 1 on the first cycle after.
  - Reset asserted mid-stream discards all queued entries; in-flight handshakes that cycle are ignored.

## Timing
- Accept-to-`out_valid` latency: 1 cycle. A LUI accepted at edge N is visible after edge N and can pop at edge N+1.
- Counters update at the accepting edge, visible the following cycle.
- `in_ready` depends only on registered occupancy plus `flush`/`rst`. There is no combinational path from `out_ready`.
- `out_valid`, `out_op` and `out_imm` are registered-state derived; there is no combinational path from `in_*`.
- Sustained throughput: 1 entry/cycle when the downstream is always ready and the FIFO is not full.

## Test plan
- Reset then single LUI: `in_insn=32'h123450B7` (LUI x1, 0x12345) with `out_ready=0`. Required next cycle: `out_valid=1`, `out_op=1`, `out_imm=20'h12345`, `lui_count=1`. Raise `out_ready`; required the following cycle: `out_valid=0`, `out_op=0`.
- Filtering: push `32'h00000013` (ADDI nop), then `32'hFFFFF037` (LUI x0). Required: `drop_count=1`, `lui_count=1`, one entry with `out_op=0` and `out_imm=20'hFFFFF`.
- Full/back-pressure: `out_ready=0`; push DEPTH+2 LUIs with rd 1..6.
  - `in_ready` drops after the 4th accept; words 5 and 6 stall.
  - Draining yields rd 1,2,3,4, then 5,6 in order.
  - Pointers wrap correctly.
- Streaming: `in_valid=1` and `out_ready=1` for 20 LUIs with rd = i mod 32. Required: every word accepted back-to-back, outputs in order, occupancy ≤1.
- Flush/reset mid-operation:
  - Fill 3 entries, then assert `flush` one cycle together with `in_valid`. Required: `out_valid=0` next cycle, `in_ready=0` during the flush, counters hold at 3.
  - Repeat with `rst` instead. Required: counters return to 0.
- Saturation with `CNT_W=4`: push 20 non-LUI words. Required: `drop_count` stops at 15 and `lui_count` stays 0.
